// File: rtl/narrow_pkg.sv
// Shared types and the 16->12 signed narrowing function.
// SIGN_NARROW_SAT_EN selects saturation of out-of-range values; the default build truncates.
package narrow_pkg;

   localparam int IN_W  = 16;
   localparam int OUT_W = 12;

   localparam logic [OUT_W-1:0] SAT_MAX = 12'h7FF;
   localparam logic [OUT_W-1:0] SAT_MIN = 12'h800;

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic             ovf;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

   // A value fits in 12 signed bits exactly when the top five bits are all copies of the sign.
   function automatic entry_t narrow(input logic [IN_W-1:0] d);
      entry_t e;
      logic   fits;
      fits  = (d[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){d[IN_W-1]}});
      e.ovf = ~fits;
`ifdef SIGN_NARROW_SAT_EN
      if (fits)
         e.data = d[OUT_W-1:0];
      else
         e.data = d[IN_W-1] ? SAT_MIN : SAT_MAX;
`else
      e.data = d[OUT_W-1:0];
`endif
      return e;
   endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry skid buffer (main + skid register) with registered in_ready/out_valid.
// state    | meaning
// ST_EMPTY | no entry held, out_valid low
// ST_ONE   | main register valid, skid empty
// ST_FULL  | main and skid valid, in_ready low
module skid_buf
   import narrow_pkg::*;
#(
   parameter type entry_type = narrow_pkg::entry_t
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      in_valid,
   output logic      in_ready,
   input  entry_type in_entry,
   output logic      out_valid,
   input  logic      out_ready,
   output entry_type out_entry
);

   skid_state_t state;
   entry_type   main_q;
   entry_type   skid_q;
   logic        in_xfer;

   assign in_xfer   = in_valid & in_ready;
   assign out_entry = main_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
         main_q    <= '0;
         skid_q    <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               in_ready <= 1'b1;
               if (in_xfer) begin
                  main_q    <= in_entry;
                  out_valid <= 1'b1;
                  state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && !out_ready) begin
                  skid_q   <= in_entry;
                  in_ready <= 1'b0;
                  state    <= ST_FULL;
               end else if (in_xfer) begin
                  main_q <= in_entry;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  main_q   <= skid_q;
                  in_ready <= 1'b1;
                  state    <= ST_ONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b0;
               state     <= ST_EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/sign_narrow_16to12.sv
// Narrows 16-bit signed samples to 12 bits through a skid buffer and counts overflows.
// Build option: SIGN_NARROW_SAT_EN (saturate instead of truncate; see narrow_pkg).
module sign_narrow_16to12
   import narrow_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_ovf,
   output logic [CNT_W-1:0]  ovf_cnt,
   input  logic              cnt_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   entry_t in_entry;
   entry_t out_entry;
   logic   count_evt;

   assign in_entry  = narrow(in_data);
   assign count_evt = in_valid & in_ready & in_entry.ovf;
   assign out_data  = out_entry.data;
   assign out_ovf   = out_entry.ovf;

   skid_buf #(
      .entry_type (entry_t)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_entry  (in_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_entry (out_entry)
   );

   // A clear coinciding with an overflow leaves that overflow counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_cnt <= '0;
      else if (cnt_clr)
         ovf_cnt <= count_evt ? CNT_W'(1) : '0;
      else if (count_evt && (ovf_cnt != CNT_MAX))
         ovf_cnt <= ovf_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_sign_narrow_16to12.sv
// Self-checking bench for sign_narrow_16to12: vector table, backpressure, counter, reset and random stress.
module tb_sign_narrow_16to12;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, out_ovf, cnt_clr;
   logic [15:0] in_data;
   logic [11:0] out_data;
   logic [7:0]  ovf_cnt;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_ovf, s_cnt_clr;
   logic [15:0] s_in_data;
   logic [11:0] s_out_data;
   logic [1:0]  s_ovf_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sign_narrow_16to12 #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
      .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
   );

   sign_narrow_16to12 #(.CNT_W(2)) dut_small (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_ovf(s_out_ovf),
      .ovf_cnt(s_ovf_cnt), .cnt_clr(s_cnt_clr)
   );

   typedef struct {
      logic [15:0] din;
      logic [11:0] exp_data;
      logic        exp_ovf;
      logic [7:0]  exp_cnt;
   } vec_t;

   vec_t vecs[9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Independent range-based reference: {ovf, data}.
   function automatic logic [12:0] ref_narrow(input logic [15:0] d);
      logic fits;
      logic [11:0] r;
      fits = ($signed(d) >= -16'sd2048) && ($signed(d) <= 16'sd2047);
      r = d[11:0];
`ifdef SIGN_NARROW_SAT_EN
      if (!fits) r = d[15] ? 12'h800 : 12'h7FF;
`endif
      return {~fits, r};
   endfunction

   initial begin
      logic [12:0] q[$];
      logic [12:0] exp_e;
      logic [11:0] rnd12;
      int          mcnt;

`ifdef SIGN_NARROW_SAT_EN
      vecs[0] = '{16'h07FF, 12'h7FF, 1'b0, 8'd0};
      vecs[1] = '{16'hF800, 12'h800, 1'b0, 8'd0};
      vecs[2] = '{16'h0000, 12'h000, 1'b0, 8'd0};
      vecs[3] = '{16'hFFFF, 12'hFFF, 1'b0, 8'd0};
      vecs[4] = '{16'h0800, 12'h7FF, 1'b1, 8'd1};
      vecs[5] = '{16'h8000, 12'h800, 1'b1, 8'd2};
      vecs[6] = '{16'hFC00, 12'hC00, 1'b0, 8'd2};
      vecs[7] = '{16'h7FFF, 12'h7FF, 1'b1, 8'd3};
      vecs[8] = '{16'hF7FF, 12'h800, 1'b1, 8'd4};
`else
      vecs[0] = '{16'h07FF, 12'h7FF, 1'b0, 8'd0};
      vecs[1] = '{16'hF800, 12'h800, 1'b0, 8'd0};
      vecs[2] = '{16'h0000, 12'h000, 1'b0, 8'd0};
      vecs[3] = '{16'hFFFF, 12'hFFF, 1'b0, 8'd0};
      vecs[4] = '{16'h0800, 12'h800, 1'b1, 8'd1};
      vecs[5] = '{16'h8000, 12'h000, 1'b1, 8'd2};
      vecs[6] = '{16'hFC00, 12'hC00, 1'b0, 8'd2};
      vecs[7] = '{16'h7FFF, 12'hFFF, 1'b1, 8'd3};
      vecs[8] = '{16'hF7FF, 12'h7FF, 1'b1, 8'd4};
`endif

      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clr = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1; s_cnt_clr = 1'b0;

      // reset state
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_data", 32'(out_data), 32'h000);
      check("rst_out_ovf", 32'(out_ovf), 32'd0);
      check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready_hold", 32'(in_ready), 32'd0);
      tick();
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // table-driven stream, one value per cycle
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_data  = vecs[i].din;
         tick();
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d_ovf", i), 32'(out_ovf), 32'(vecs[i].exp_ovf));
         check($sformatf("vec%0d_cnt", i), 32'(ovf_cnt), 32'(vecs[i].exp_cnt));
      end
      in_valid = 1'b0;
      tick();
      check("stream_drained", 32'(out_valid), 32'd0);

      // backpressure: A accepted, B to skid, C refused
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0123;
      tick();
      check("bp_a_valid", 32'(out_valid), 32'd1);
      check("bp_a_in_ready", 32'(in_ready), 32'd1);
      in_data = 16'h8000;
      tick();
      check("bp_b_in_ready", 32'(in_ready), 32'd0);
      check("bp_b_hold", 32'(out_data), 32'h123);
      in_data = 16'hFFF0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_stall_in_ready", 32'(in_ready), 32'd0);
         check("bp_stall_valid", 32'(out_valid), 32'd1);
         check("bp_stall_data", 32'({out_ovf, out_data}), 32'h0123);
      end
      out_ready = 1'b1;
      tick();
      exp_e = ref_narrow(16'h8000);
      check("bp_out_b", 32'({out_ovf, out_data}), 32'(exp_e));
      check("bp_drain_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("bp_out_c", 32'({out_ovf, out_data}), 32'h0FF0);
      check("bp_out_c_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      tick();
      check("bp_done", 32'(out_valid), 32'd0);

      // counter clear alone, then clear with an overflowing transfer
      cnt_clr = 1'b1;
      tick();
      check("clr_alone", 32'(ovf_cnt), 32'd0);
      in_valid = 1'b1;
      in_data  = 16'h4000;
      tick();
      check("clr_with_ovf", 32'(ovf_cnt), 32'd1);
      cnt_clr  = 1'b0;
      in_valid = 1'b0;
      tick();

      // 2-bit counter saturation
      s_in_valid = 1'b1;
      s_in_data  = 16'h4000;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("sat_cnt%0d", i), 32'(s_ovf_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      end
      s_cnt_clr = 1'b1;
      tick();
      check("small_clr_with_ovf", 32'(s_ovf_cnt), 32'd1);
      s_cnt_clr  = 1'b0;
      s_in_valid = 1'b0;
      tick();

      // reset while both entries are valid
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0111;
      tick();
      in_data = 16'h0222;
      tick();
      check("mid_full", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_data", 32'(out_data), 32'h000);
      #10;
      rst_n = 1'b1;
      tick();
      check("mid_rst_rise", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h0333;
      tick();
      check("mid_rst_first_valid", 32'(out_valid), 32'd1);
      check("mid_rst_first_data", 32'(out_data), 32'h333);
      in_valid = 1'b0;
      tick();
      check("mid_rst_no_stale", 32'(out_valid), 32'd0);

      // random stress against scoreboard
      mcnt = 0;
      for (int c = 0; c < 10000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) begin
            in_data = 16'($urandom);
         end else begin
            rnd12   = 12'($urandom);
            in_data = {{4{rnd12[11]}}, rnd12};
         end
         #1;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("rnd_unexpected_out", 32'd1, 32'd0);
            end else begin
               exp_e = q.pop_front();
               check("rnd_out", 32'({out_ovf, out_data}), 32'(exp_e));
            end
         end
         if (in_valid && in_ready) begin
            exp_e = ref_narrow(in_data);
            q.push_back(exp_e);
            if (exp_e[12] && mcnt < 255) mcnt++;
         end
         tick();
         check("rnd_cnt", 32'(ovf_cnt), 32'(mcnt));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (out_valid && q.size() != 0) begin
            exp_e = q.pop_front();
            check("rnd_drain", 32'({out_ovf, out_data}), 32'(exp_e));
         end
         tick();
      end
      check("rnd_queue_empty", 32'(q.size()), 32'd0);
      check("rnd_final_idle", 32'(out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sign_narrow_16to12.md
SIGN_NARROW_16TO12 -- requirements
Module: sign_narrow_16to12

Interface
REQ-001 Parameter: CNT_W, default 8, width of the overflow event counter.
REQ-002 Port: clk  input  1  single clock; all state is updated on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  in_data holds a value to narrow.
REQ-005 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-006 Port: in_data  input  16  two's-complement value to narrow.
REQ-007 Port: out_valid  output  1  out_data and out_ovf are valid.
REQ-008 Port: out_ready  input  1  consumer takes the output this cycle.
REQ-009 Port: out_data  output  12  narrowed two's-complement value.
REQ-010 Port: out_ovf  output  1  in_data did not fit in signed 12 bits.
REQ-011 Port: ovf_cnt  output  CNT_W  count of overflowed transfers accepted.
REQ-012 Port: cnt_clr  input  1  synchronous clear of ovf_cnt.

Function
REQ-013 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-014 Fit test: the value fits exactly when in_data[15:11] are all equal; out_ovf SHALL be the negation of the fit test.
REQ-015 A value that fits SHALL produce out_data = in_data[11:0], so that sign-extending out_data back to 16 bits reproduces in_data.
REQ-016 Latency SHALL be exactly 1 cycle: a value accepted in cycle N SHALL appear on out_valid/out_data in cycle N+1.
REQ-017 Buffering SHALL be a 2-entry skid buffer (main register plus skid register), so that throughput is one transfer per cycle while out_ready stays high.
REQ-018 in_ready SHALL be registered and SHALL equal NOT(skid register valid).
REQ-019 Skid fill: when out_valid=1, out_ready=0 and an input transfer occurs, the incoming entry SHALL go to the skid register and in_ready SHALL drop on the next cycle.
REQ-020 Skid drain: on an output transfer with the skid register valid, the skid entry SHALL move to the main register and in_ready SHALL rise on the next cycle.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_ovf SHALL be held stable.
REQ-022 Ordering SHALL be FIFO; no entry SHALL be dropped or duplicated.
REQ-023 ovf_cnt SHALL increment on each input transfer whose value fails the fit test.
REQ-024 ovf_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-025 If cnt_clr and a counting transfer occur in the same cycle, ovf_cnt SHALL become 1; cnt_clr alone SHALL set ovf_cnt to 0.

Reset
REQ-026 While rst_n is low: out_valid=0, in_ready=0, both buffer entries invalid, out_data=0x000, out_ovf=0, ovf_cnt=0.
REQ-027 After rst_n deasserts, in_ready SHALL rise on the first clock edge.
REQ-028 Reset asserted mid-transfer SHALL discard both buffered entries immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro SIGN_NARROW_SAT_EN defined: an overflowed value SHALL saturate out_data to 0x7FF when in_data[15]=0 and to 0x800 when in_data[15]=1.
REQ-030 Macro SIGN_NARROW_SAT_EN undefined: an overflowed value SHALL truncate, out_data = in_data[11:0].
REQ-031 out_ovf and ovf_cnt behaviour SHALL be identical in both builds.

Structure
REQ-032 The package narrow_pkg SHALL hold: the widths IN_W=16 and OUT_W=12, the saturation constants SAT_MAX=12'h7FF and SAT_MIN=12'h800, and a packed struct entry_t {data[11:0], ovf}.
REQ-033 The fit test and the narrowing SHALL be a combinational function in narrow_pkg.
REQ-034 The skid buffer SHALL be one sub-module, skid_buf, parameterised on entry_t.

Verification
REQ-035 Fitting values: stream 0x07FF, 0xF800, 0x0000, 0xFFFF with out_ready=1 -> out_data 0x7FF, 0x800, 0x000, 0xFFF, out_ovf=0, one per cycle, ovf_cnt=0.
REQ-036 Overflow: send 0x0800 and 0x8000 -> out_ovf=1 on both, ovf_cnt=2; SAT build gives 0x7FF then 0x800; truncate build gives 0x800 then 0x000.
REQ-037 Backpressure: out_ready=0, send 3 values back-to-back -> 2 accepted, in_ready low from the cycle after the second acceptance; raise out_ready -> all 3 delivered in order, outputs held stable while stalled.
REQ-038 Counter limits: CNT_W=2, send 5 overflowing values -> ovf_cnt reaches 3 and stays there; cnt_clr in the same cycle as an overflowing transfer -> ovf_cnt=1.
REQ-039 Reset mid-stream: assert rst_n low while both buffer entries are valid -> out_valid=0 and in_ready=0 immediately; after release, the first output is the first value sent after reset.
REQ-040 Random stress: 10k random values with random valid/ready -> scoreboard matches the package reference function, and ovf_cnt equals the number of overflowed transfers (saturated).
